// File: rtl/beu_clmul_pkg.sv
// Shared types and defaults for the carry-less multiply unit.
package beu_clmul_pkg;

    localparam int CLMUL_XLEN_DEF = 32;
    localparam int CLMUL_STEP_DEF = 4;

    typedef enum logic [1:0] {
        CLMUL_L = 2'd0,
        CLMUL_H = 2'd1,
        CLMUL_R = 2'd2
    } clmul_mode;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } clmul_state_e;

endpackage

// File: rtl/beu_clmul_if.sv
// Request/result handshake bundle between the execute stage and beu_clmul.
interface beu_clmul_if #(
    parameter int XLEN = 32
);
    logic            s_flush_i;
    logic            s_valid_i;
    logic            s_ready_o;
    logic [1:0]      s_mode_i;
    logic [XLEN-1:0] s_op1_i;
    logic [XLEN-1:0] s_op2_i;
    logic            s_valid_o;
    logic            s_ready_i;
    logic [XLEN-1:0] s_result_o;

    modport master (
        output s_flush_i, s_valid_i, s_mode_i, s_op1_i, s_op2_i, s_ready_i,
        input  s_ready_o, s_valid_o, s_result_o
    );

    modport slave (
        input  s_flush_i, s_valid_i, s_mode_i, s_op1_i, s_op2_i, s_ready_i,
        output s_ready_o, s_valid_o, s_result_o
    );
endinterface

// File: rtl/beu_clmul_step.sv
// One STEP-bit slice of carry-less multiplication: folds the low multiplier
// bits into the accumulator.
module clmul_step #(
    parameter int XLEN = 32,
    parameter int STEP = 4
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] mcand_i,
    input  logic [STEP-1:0]   mplr_i,
    output logic [2*XLEN-1:0] acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int j = 0; j < STEP; j++) begin
            if (mplr_i[j]) begin
                acc_o = acc_o ^ (mcand_i << j);
            end
        end
    end

endmodule

// File: rtl/beu_clmul.sv
// Multi-cycle carry-less multiply (clmul/clmulh/clmulr) with early
// termination once the remaining multiplier bits are all zero.
module beu_clmul
    import beu_clmul_pkg::*;
#(
    parameter int XLEN = CLMUL_XLEN_DEF,
    parameter int STEP = CLMUL_STEP_DEF
) (
    input  logic       s_clk_i,
    input  logic       s_reset_i,
    beu_clmul_if.slave bus
);

    if (STEP < 1 || (XLEN % STEP) != 0) begin : g_bad_step
        $error("beu_clmul: STEP must be >= 1 and divide XLEN");
    end

    clmul_state_e    state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplr_q, mplr_d;
    logic [1:0]      mode_q, mode_d;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0] mplr_shift;

    clmul_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .mplr_i  (mplr_q[STEP-1:0]),
        .acc_o   (acc_step)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        mode_d     = mode_q;
        mplr_shift = mplr_q >> STEP;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.s_valid_i) begin
                    acc_d   = '0;
                    mcand_d = {{XLEN{1'b0}}, bus.s_op1_i};
                    mplr_d  = bus.s_op2_i;
                    mode_d  = bus.s_mode_i;
                    // Zero multiplier or reserved mode: nothing to accumulate.
                    if (bus.s_op2_i == '0 || bus.s_mode_i == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << STEP;
                mplr_d  = mplr_shift;
                if (mplr_shift == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.s_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.s_flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.s_ready_o = (state_q == ST_IDLE);
    assign bus.s_valid_o = (state_q == ST_DONE);

    always_comb begin
        bus.s_result_o = '0;
        if (state_q == ST_DONE) begin
            unique case (mode_q)
                CLMUL_L: bus.s_result_o = acc_q[XLEN-1:0];
                CLMUL_H: bus.s_result_o = acc_q[2*XLEN-1:XLEN];
                CLMUL_R: bus.s_result_o = acc_q[2*XLEN-2:XLEN-1];
                default: bus.s_result_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_beu_clmul.sv
// Scoreboard bench: three beu_clmul instances (STEP 4, 1, 32) share stimulus.
module tb_beu_clmul;
    import beu_clmul_pkg::*;

    localparam int NDUT = 3;
    localparam int STEPS [NDUT] = '{4, 1, 32};

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush, valid_in, ready_in;
    logic [1:0]  mode;
    logic [31:0] op1, op2;

    logic [NDUT-1:0]        rdy, vld, vld_prev;
    logic [NDUT-1:0][31:0]  res;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q [NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        beu_clmul_if #(.XLEN(32)) if_b ();
        beu_clmul #(.XLEN(32), .STEP(STEPS[g])) u_dut (
            .s_clk_i   (clk),
            .s_reset_i (rst),
            .bus       (if_b.slave)
        );
        assign if_b.s_flush_i = flush;
        assign if_b.s_valid_i = valid_in;
        assign if_b.s_mode_i  = mode;
        assign if_b.s_op1_i   = op1;
        assign if_b.s_op2_i   = op2;
        assign if_b.s_ready_i = ready_in;
        assign rdy[g] = if_b.s_ready_o;
        assign vld[g] = if_b.s_valid_o;
        assign res[g] = if_b.s_result_o;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] clmul_ref(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] m);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ ({32'b0, a} << i);
        end
        case (m)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return p[62:31];
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat(input logic [31:0] b, input logic [1:0] m, input int step);
        int msb;
        if (b == 32'h0 || m == 2'd3) return 0;
        msb = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        return (msb + step) / step;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (vld[i] && !vld_prev[i]) begin
                if (sb_q[i].size() == 0) begin
                    chk($sformatf("spurious_valid%0d", i), {63'b0, vld[i]}, 64'h0);
                end else begin
                    exp_t e;
                    e = sb_q[i].pop_front();
                    chk($sformatf("result_s%0d", STEPS[i]), {32'b0, res[i]}, {32'b0, e.res});
                    chk($sformatf("latency_s%0d", STEPS[i]), 64'(cyc), 64'(e.cyc));
                end
            end
        end
        vld_prev <= vld;
    end

    // Waits for all units idle, issues one request; caller resumes #1 after E0.
    task automatic req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic [31:0] exp, input bit push);
        int t;
        int k;
        t = 0;
        while (rdy !== 3'b111 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("req_ready", {61'b0, rdy}, 64'h7);
        op1 = a; op2 = b; mode = m; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        k = cyc;
        if (push) begin
            for (int i = 0; i < NDUT; i++) begin
                sb_q[i].push_back('{exp, k + lat(b, m, STEPS[i])});
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rdy !== 3'b111 || sb_q[0].size() != 0 || sb_q[1].size() != 0 ||
                sb_q[2].size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", {61'b0, sb_q[2].size() == 0, sb_q[1].size() == 0, sb_q[0].size() == 0},
            64'h7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] a, b;
        logic [1:0]  m;

        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        mode = 2'd0; op1 = '0; op2 = '0; vld_prev = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {61'b0, rdy}, 64'h7);
        chk("rst_valid", {61'b0, vld}, 64'h0);
        chk("rst_result", {32'b0, res[0]}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases with constant expectations
        req(32'h3, 32'h3, CLMUL_L, 32'h0000_0005, 1);
        drain();
        req(32'hFFFF_FFFF, 32'hFFFF_FFFF, CLMUL_L, 32'h5555_5555, 1);
        req(32'hFFFF_FFFF, 32'hFFFF_FFFF, CLMUL_H, 32'h5555_5555, 1);
        req(32'hFFFF_FFFF, 32'hFFFF_FFFF, CLMUL_R, 32'hAAAA_AAAA, 1);
        req(32'h8000_0000, 32'h8000_0000, CLMUL_H, 32'h4000_0000, 1);
        req(32'h8000_0000, 32'h8000_0000, CLMUL_R, 32'h8000_0000, 1);
        req(32'h8000_0000, 32'h8000_0000, CLMUL_L, 32'h0000_0000, 1);
        req(32'h1234_5678, 32'h0, CLMUL_L, 32'h0, 1);
        req(32'h1234_5678, 32'h0000_00FF, 2'd3, 32'h0, 1);
        drain();

        // Backpressure: hold the result in DONE
        ready_in = 1'b0;
        req(32'hFFFF_FFFF, 32'hFFFF_FFFF, CLMUL_L, 32'h5555_5555, 1);
        @(negedge clk);
        chk("busy_result_zero", {32'b0, res[0]}, 64'h0);
        chk("busy_not_ready", {63'b0, rdy[0]}, 64'h0);
        t = 0;
        while (vld !== 3'b111 && t < 100) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_result", {32'b0, res[0]}, 64'h5555_5555);
            chk("hold_valid", {63'b0, vld[0]}, 64'h1);
            chk("hold_not_ready", {63'b0, rdy[0]}, 64'h0);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
        drain();

        // Flush while busy
        req(32'h1234_5678, 32'hF000_0001, CLMUL_L, 32'h0, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", {61'b0, rdy}, 64'h7);
        chk("flush_valid", {61'b0, vld}, 64'h0);
        repeat (12) @(posedge clk);
        #1;

        // Flush beats a simultaneous request
        op1 = 32'h5; op2 = 32'h0; mode = CLMUL_L; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_req_ready", {61'b0, rdy}, 64'h7);
        chk("flush_vs_req_valid", {61'b0, vld}, 64'h0);
        req(32'hDEAD_BEEF, 32'h0000_0013, CLMUL_L, clmul_ref(32'hDEAD_BEEF, 32'h13, 2'd0), 1);
        drain();

        // Reset while busy
        req(32'hCAFE_F00D, 32'h8765_4321, CLMUL_H, 32'h0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {61'b0, rdy}, 64'h7);
        chk("reset_valid", {61'b0, vld}, 64'h0);
        chk("reset_result", {32'b0, res[0]}, 64'h0);
        repeat (12) @(posedge clk);
        #1;
        req(32'hCAFE_F00D, 32'h8765_4321, CLMUL_H, clmul_ref(32'hCAFE_F00D, 32'h8765_4321, 2'd1), 1);
        drain();

        // Random operands against the reference model
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 15) == 0) b = 32'h0;
            m = 2'($urandom_range(0, 3));
            req(a, b, m, clmul_ref(a, b, m), 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
